// File: rtl/easyaxi_rd_slv_pkg.sv
// Shared AXI widths, encodings and request types for the EASYAXI read slave.
package easyaxi_rd_slv_pkg;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_1B = 3'd0;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_2B = 3'd1;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B = 3'd2;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_8B = 3'd3;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // widest beat the data bus can carry, as an arsize value
  localparam int AXI_MAX_SIZE = $clog2(AXI_DATA_W / 8);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} rd_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } ar_req_t;
endpackage

// File: rtl/easyaxi_rd_if.sv
// AR/R channel bundle between the EASYAXI read master and slave.
interface easyaxi_rd_if;
  import easyaxi_rd_slv_pkg::*;

  logic                   axi_slv_arvalid;
  logic                   axi_slv_arready;
  logic [AXI_ID_W-1:0]    axi_slv_arid;
  logic [AXI_ADDR_W-1:0]  axi_slv_araddr;
  logic [AXI_LEN_W-1:0]   axi_slv_arlen;
  logic [AXI_SIZE_W-1:0]  axi_slv_arsize;
  logic [AXI_BURST_W-1:0] axi_slv_arburst;
  logic                   axi_slv_rvalid;
  logic                   axi_slv_rready;
  logic [AXI_ID_W-1:0]    axi_slv_rid;
  logic [AXI_DATA_W-1:0]  axi_slv_rdata;
  logic [AXI_RESP_W-1:0]  axi_slv_rresp;
  logic                   axi_slv_rlast;

  modport slv (
    input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
           axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
    output axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
           axi_slv_rresp, axi_slv_rlast
  );

  modport mst (
    output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
           axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
    input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
           axi_slv_rresp, axi_slv_rlast
  );
endinterface

// File: rtl/easyaxi_burst_addr.sv
// Next beat address and burst legality for one AXI read burst descriptor.
module easyaxi_burst_addr
  import easyaxi_rd_slv_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0]  addr,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_SIZE_W-1:0]  size,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [AXI_ADDR_W-1:0]  next_addr,
  output logic                   slverr
);
  logic [AXI_ADDR_W-1:0] bytes, total, base;
  logic                  wrap_len_ok;

  always_comb begin
    bytes = AXI_ADDR_W'(1) << size;
    total = (AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size;
    base  = addr & ~(total - AXI_ADDR_W'(1));
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_INCR:  next_addr = (addr & ~(bytes - AXI_ADDR_W'(1))) + bytes;
      AXI_BURST_WRAP:  next_addr = base | ((addr + bytes) & (total - AXI_ADDR_W'(1)));
      default:         next_addr = addr;
    endcase
    wrap_len_ok = (len == AXI_LEN_W'(1)) || (len == AXI_LEN_W'(3)) ||
                  (len == AXI_LEN_W'(7)) || (len == AXI_LEN_W'(15));
    slverr = (burst == AXI_BURST_RSVD) ||
             ((burst == AXI_BURST_WRAP) && !wrap_len_ok) ||
             (size > AXI_SIZE_W'(AXI_MAX_SIZE));
  end
endmodule

// File: rtl/easyaxi_rd_slv.sv
// AXI read slave: queues AR requests in order and replays each as an R burst
// whose data is the beat address, after a fixed first-beat latency.
module easyaxi_rd_slv
  import easyaxi_rd_slv_pkg::*;
#(
  parameter int                    OST_DEPTH  = 16,
  parameter int                    RD_LATENCY = 2,
  parameter logic [AXI_ADDR_W-1:0] ADDR_LIMIT = 'h100
) (
  input logic       clk,
  input logic       rst_n,
  easyaxi_rd_if.slv axi
);
  localparam int PW = $clog2(OST_DEPTH);
  localparam logic [3:0] LAT0 = 4'(RD_LATENCY);

  // ---------------- AR queue ----------------
  logic [PW:0] set_ptr, clr_ptr;
  logic        full, empty, push, pop;
  ar_req_t     mem [OST_DEPTH];
  ar_req_t     head, push_req;
  rd_state_e   state;

  assign full  = (set_ptr[PW] != clr_ptr[PW]) && (set_ptr[PW-1:0] == clr_ptr[PW-1:0]);
  assign empty = (set_ptr == clr_ptr);
  assign axi.axi_slv_arready = ~full;
  assign push = axi.axi_slv_arvalid & ~full;
  assign pop  = (state == ST_IDLE) & ~empty;
  assign head = mem[clr_ptr[PW-1:0]];

  assign push_req = '{id:    axi.axi_slv_arid,
                      addr:  axi.axi_slv_araddr,
                      len:   axi.axi_slv_arlen,
                      size:  axi.axi_slv_arsize,
                      burst: axi.axi_slv_arburst};

  always_ff @(posedge clk) begin
    if (push) mem[set_ptr[PW-1:0]] <= push_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_ptr <= '0;
      clr_ptr <= '0;
    end else begin
      if (push) set_ptr <= set_ptr + 1'b1;
      if (pop)  clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // ---------------- burst engine ----------------
  ar_req_t               w_req, cur;
  logic                  w_slverr, slverr;
  logic [AXI_LEN_W-1:0]  beat_cnt;
  logic [3:0]            lat_cnt;
  logic [AXI_ADDR_W-1:0] next_addr;
  logic                  rvalid, rlast;
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_RESP_W-1:0] rresp;

  // while idle the checker looks at the queue head so a zero-latency pop
  // can present beat 0 with its response already resolved
  assign cur = (state == ST_IDLE) ? head : w_req;

  easyaxi_burst_addr u_addr (
    .addr      (cur.addr),
    .len       (cur.len),
    .size      (cur.size),
    .burst     (cur.burst),
    .next_addr (next_addr),
    .slverr    (slverr)
  );

  function automatic logic [AXI_RESP_W-1:0] beat_resp(input logic [AXI_ADDR_W-1:0] a,
                                                      input logic se);
    if (se)                   return AXI_RESP_SLVERR;
    else if (a >= ADDR_LIMIT) return AXI_RESP_DECERR;
    else                      return AXI_RESP_OKAY;
  endfunction

  function automatic logic [AXI_DATA_W-1:0] beat_data(input logic [AXI_ADDR_W-1:0] a,
                                                      input logic se);
    return (se || (a >= ADDR_LIMIT)) ? '0 : AXI_DATA_W'(a);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      w_req    <= '0;
      w_slverr <= 1'b0;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
      rlast    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            w_req    <= head;
            w_slverr <= slverr;
            beat_cnt <= '0;
            lat_cnt  <= LAT0;
            if (RD_LATENCY == 0) begin
              state  <= ST_DATA;
              rvalid <= 1'b1;
              rid    <= head.id;
              rdata  <= beat_data(head.addr, slverr);
              rresp  <= beat_resp(head.addr, slverr);
              rlast  <= (head.len == '0);
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state  <= ST_DATA;
            rvalid <= 1'b1;
            rid    <= w_req.id;
            rdata  <= beat_data(w_req.addr, w_slverr);
            rresp  <= beat_resp(w_req.addr, w_slverr);
            rlast  <= (w_req.len == '0);
          end
        end
        ST_DATA: begin
          if (axi.axi_slv_rready) begin
            if (rlast) begin
              state  <= ST_IDLE;
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              w_req.addr <= next_addr;
              beat_cnt   <= beat_cnt + 1'b1;
              rdata      <= beat_data(next_addr, w_slverr);
              rresp      <= beat_resp(next_addr, w_slverr);
              rlast      <= ((beat_cnt + 1'b1) == w_req.len);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign axi.axi_slv_rvalid = rvalid;
  assign axi.axi_slv_rid    = rid;
  assign axi.axi_slv_rdata  = rdata;
  assign axi.axi_slv_rresp  = rresp;
  assign axi.axi_slv_rlast  = rlast;
endmodule
